instruction_fetch_buffer: RTL

//  Consumer end of the program_counter's next_instruction stream. Issues one instruction-memory read per

---
 rtl/instruction_fetch_buffer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/instruction_fetch_buffer.sv
// Instruction fetch buffer: issues imem reads for accepted PC values, tracks fixed-latency reads in flight,
// and buffers returned words in order for decode. Optional same-cycle bypass when FETCH_BYPASS_EN is defined.
module instruction_fetch_buffer #(
  parameter int DEPTH       = 4,
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] next_instruction,
  input  logic                  jump,
  output logic                  pc_stall,
  output logic                  imem_read,
  output logic [ADDR_WIDTH-1:0] imem_address,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_address,
  input  logic                  decode_ready
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int OCC_W = $clog2(DEPTH + MEM_LATENCY + 1);

  logic [DATA_WIDTH-1:0]  fifo_data [DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_addr [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [MEM_LATENCY-1:0] pipe_valid;
  logic [ADDR_WIDTH-1:0]  pipe_addr [MEM_LATENCY];

  logic [OCC_W-1:0]      inflight;
  logic [OCC_W-1:0]      occupancy;
  logic                  issue;
  logic                  fifo_empty;
  logic                  resp_valid;
  logic [ADDR_WIDTH-1:0] resp_addr;
  logic                  bypass_hit;
  logic                  bypass_take;
  logic                  enq;
  logic                  deq;

  // Issue control: queued plus in-flight fetches never exceed DEPTH, so every response has a slot.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' with every output given a default first; this keeps
    // the logic purely combinational and prevents latch inference on any path.
    inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      inflight = inflight + OCC_W'(pipe_valid[i]);
    end
    occupancy    = OCC_W'(count) + inflight;
    issue        = !reset && !jump && (occupancy < OCC_W'(DEPTH));
    imem_read    = issue;
    imem_address = issue ? next_instruction : '0;
    pc_stall     = !reset && !jump && !issue;
    resp_valid   = pipe_valid[MEM_LATENCY-1] && !jump && !reset;
    resp_addr    = pipe_addr[MEM_LATENCY-1];
    fifo_empty   = (count == '0);
  end

  // Decode-side output selection and FIFO push/pop decisions.
  always_comb begin
`ifdef FETCH_BYPASS_EN
    bypass_hit = fifo_empty && resp_valid;
`else
    bypass_hit = 1'b0;
`endif
    instr_valid   = !reset && (!fifo_empty || bypass_hit);
    instr         = '0;
    instr_address = '0;
    if (bypass_hit) begin
      instr         = imem_data;
      instr_address = resp_addr;
    end else if (instr_valid) begin
      instr         = fifo_data[rd_ptr];
      instr_address = fifo_addr[rd_ptr];
    end
    bypass_take = bypass_hit && decode_ready;
    deq         = instr_valid && decode_ready && !jump && !bypass_hit;
    enq         = resp_valid && !bypass_take;
  end

  // Control state; a jump flushes exactly like reset and wins over a same-cycle dequeue.
  always_ff @(posedge clock) begin
    if (reset || jump) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= issue;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the FIFO storage and pipe addresses carry no reset; they are only observed when the
  // matching valid/count state says so, and the outputs are forced to zero otherwise.
  always_ff @(posedge clock) begin
    pipe_addr[0] <= next_instruction;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      pipe_addr[i] <= pipe_addr[i-1];
    end
    if (enq) begin
      fifo_data[wr_ptr] <= imem_data;
      fifo_addr[wr_ptr] <= resp_addr;
    end
  end

`ifndef SYNTHESIS
  no_overflow: assert property (@(posedge clock) disable iff (reset)
    !(enq && !deq && (count == CNT_W'(DEPTH))));
`endif

endmodule
